// File: rtl/cpu_controller.sv
// cpu_controller: multicycle Moore control unit for the 8-bit accumulator CPU.
// Sequences fetch, memory access, ALU, write-back and jump cycles, one
// instruction at a time, and drives every datapath enable and mux select.
// Optional feature macro: CPU_COND_BRANCH_EN. When it is defined, BZ/BC take
// the jump on zFlag/cFlag. When it is undefined, BZ/BC execute as 3-cycle NOPs.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       subOp,
    input  logic       zFlag,
    input  logic       cFlag,
    output logic       pcEn,
    output logic       mr,
    output logic       mw,
    output logic       wordRegEn,
    output logic       LSEn,
    output logic       RSEn,
    output logic       DIEn,
    output logic       enb,
    output logic       dataRegEn,
    output logic       resultRegEn,
    output logic       CEn,
    output logic       ZEn,
    output logic       NEn,
    output logic       selAddress,
    output logic       pcSrc,
    output logic [1:0] selData,
    output logic [1:0] selAddressAC,
    output logic       selALUsrc,
    output logic [1:0] aluOp,
    output logic       instrDone,
    output logic       halted
);

    typedef enum logic [3:0] {
        FETCH1, FETCH2, MEMRD, ALU, RDAC, WBW, WBR, WBD, MEMWR, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_LDA = 3'b000, OP_STA = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
        OP_JMP = 3'b100, OP_BZ  = 3'b101, OP_BC  = 3'b110, OP_SYS = 3'b111
    } op_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       sub_q, sub_d;
    logic       take_jump;

`ifdef CPU_COND_BRANCH_EN
    // Conditional branches test the flags written by the previous ALU cycle
    always_comb begin
        take_jump = 1'b0;
        case (op_q)
            OP_JMP:  take_jump = 1'b1;
            OP_BZ:   take_jump = zFlag;
            OP_BC:   take_jump = cFlag;
            default: take_jump = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = zFlag ^ cFlag;

    // Only unconditional JMP loads the PC; BZ/BC fall through
    always_comb begin
        take_jump = (op_q == OP_JMP);
    end
`endif

    // State and latched-opcode registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH1;
            op_q    <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
        end
    end

    // Next-state logic; the opcode is captured only when leaving FETCH1
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sub_d   = sub_q;
        case (state_q)
            FETCH1: begin
                op_d  = opcode;
                sub_d = subOp;
                if (opcode != OP_SYS) state_d = FETCH2;
                else if (!subOp)      state_d = RDAC;
                else                  state_d = HALT;
            end
            FETCH2: begin
                case (op_q)
                    OP_LDA, OP_ADD, OP_AND: state_d = MEMRD;
                    OP_STA:                 state_d = RDAC;
                    OP_JMP, OP_BZ, OP_BC:   state_d = JUMP;
                    default:                state_d = FETCH1;
                endcase
            end
            MEMRD:   state_d = (op_q == OP_LDA) ? WBW : ALU;
            ALU:     state_d = WBR;
            RDAC:    state_d = (op_q == OP_SYS && !sub_q) ? WBD : MEMWR;
            WBW, WBR, WBD, MEMWR, JUMP: state_d = FETCH1;
            HALT:    state_d = HALT;
            default: state_d = FETCH1;
        endcase
    end

    // Moore output decode from state and latched opcode; all outputs low in reset
    always_comb begin
        pcEn         = 1'b0;
        mr           = 1'b0;
        mw           = 1'b0;
        wordRegEn    = 1'b0;
        LSEn         = 1'b0;
        RSEn         = 1'b0;
        DIEn         = 1'b0;
        enb          = 1'b0;
        dataRegEn    = 1'b0;
        resultRegEn  = 1'b0;
        CEn          = 1'b0;
        ZEn          = 1'b0;
        NEn          = 1'b0;
        selAddress   = 1'b0;
        pcSrc        = 1'b0;
        selData      = 2'd0;
        selAddressAC = 2'd0;
        selALUsrc    = 1'b0;
        aluOp        = 2'b00;
        instrDone    = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH1: begin
                    mr   = 1'b1;
                    LSEn = 1'b1;
                    pcEn = 1'b1;
                end
                FETCH2: begin
                    mr   = 1'b1;
                    RSEn = 1'b1;
                    DIEn = 1'b1;
                    pcEn = 1'b1;
                end
                MEMRD: begin
                    selAddress = 1'b1;
                    mr         = 1'b1;
                    wordRegEn  = 1'b1;
                end
                ALU: begin
                    resultRegEn = 1'b1;
                    ZEn         = 1'b1;
                    NEn         = 1'b1;
                    CEn         = (op_q == OP_ADD);
                    aluOp       = (op_q == OP_AND) ? 2'b01 : 2'b00;
                end
                RDAC: begin
                    dataRegEn    = 1'b1;
                    selAddressAC = (op_q == OP_SYS) ? 2'd2 : 2'd0;
                end
                WBW: begin
                    enb       = 1'b1;
                    instrDone = 1'b1;
                end
                WBR: begin
                    enb       = 1'b1;
                    selData   = 2'd1;
                    instrDone = 1'b1;
                end
                WBD: begin
                    enb          = 1'b1;
                    selData      = 2'd2;
                    selAddressAC = 2'd1;
                    instrDone    = 1'b1;
                end
                MEMWR: begin
                    selAddress = 1'b1;
                    mw         = 1'b1;
                    instrDone  = 1'b1;
                end
                JUMP: begin
                    pcSrc     = 1'b1;
                    pcEn      = take_jump;
                    instrDone = 1'b1;
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed per-cycle checks of every cpu_controller output.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       subOp, zFlag, cFlag;
    logic       pcEn, mr, mw, wordRegEn, LSEn, RSEn, DIEn, enb, dataRegEn;
    logic       resultRegEn, CEn, ZEn, NEn, selAddress, pcSrc, selALUsrc;
    logic       instrDone, halted;
    logic [1:0] selData, selAddressAC, aluOp;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    cpu_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .subOp(subOp),
        .zFlag(zFlag), .cFlag(cFlag),
        .pcEn(pcEn), .mr(mr), .mw(mw), .wordRegEn(wordRegEn), .LSEn(LSEn),
        .RSEn(RSEn), .DIEn(DIEn), .enb(enb), .dataRegEn(dataRegEn),
        .resultRegEn(resultRegEn), .CEn(CEn), .ZEn(ZEn), .NEn(NEn),
        .selAddress(selAddress), .pcSrc(pcSrc), .selData(selData),
        .selAddressAC(selAddressAC), .selALUsrc(selALUsrc), .aluOp(aluOp),
        .instrDone(instrDone), .halted(halted)
    );

    always #5 clk = ~clk;

    // All outputs packed into one word for comparison
    logic [23:0] obs;
    assign obs = {pcEn, mr, mw, wordRegEn, LSEn, RSEn, DIEn, enb, dataRegEn,
                  resultRegEn, CEn, ZEn, NEn, selAddress, pcSrc, selData,
                  selAddressAC, selALUsrc, aluOp, instrDone, halted};

    localparam logic [23:0] B_PCEN  = 24'h1 << 23;
    localparam logic [23:0] B_MR    = 24'h1 << 22;
    localparam logic [23:0] B_MW    = 24'h1 << 21;
    localparam logic [23:0] B_WORD  = 24'h1 << 20;
    localparam logic [23:0] B_LS    = 24'h1 << 19;
    localparam logic [23:0] B_RS    = 24'h1 << 18;
    localparam logic [23:0] B_DI    = 24'h1 << 17;
    localparam logic [23:0] B_ENB   = 24'h1 << 16;
    localparam logic [23:0] B_DATA  = 24'h1 << 15;
    localparam logic [23:0] B_RES   = 24'h1 << 14;
    localparam logic [23:0] B_CEN   = 24'h1 << 13;
    localparam logic [23:0] B_ZEN   = 24'h1 << 12;
    localparam logic [23:0] B_NEN   = 24'h1 << 11;
    localparam logic [23:0] B_SELA  = 24'h1 << 10;
    localparam logic [23:0] B_PCSRC = 24'h1 << 9;
    localparam logic [23:0] B_SD1   = 24'h1 << 7;
    localparam logic [23:0] B_SD2   = 24'h2 << 7;
    localparam logic [23:0] B_AC1   = 24'h1 << 5;
    localparam logic [23:0] B_AC2   = 24'h2 << 5;
    localparam logic [23:0] B_AND   = 24'h1 << 2;
    localparam logic [23:0] B_DONE  = 24'h1 << 1;
    localparam logic [23:0] B_HALT  = 24'h1;

    localparam logic [23:0] E_F1    = B_MR | B_LS | B_PCEN;
    localparam logic [23:0] E_F2    = B_MR | B_RS | B_DI | B_PCEN;
    localparam logic [23:0] E_MEMRD = B_SELA | B_MR | B_WORD;
    localparam logic [23:0] E_ADD   = B_RES | B_CEN | B_ZEN | B_NEN;
    localparam logic [23:0] E_AND   = B_RES | B_ZEN | B_NEN | B_AND;
    localparam logic [23:0] E_WBW   = B_ENB | B_DONE;
    localparam logic [23:0] E_WBR   = B_ENB | B_SD1 | B_DONE;
    localparam logic [23:0] E_WBD   = B_ENB | B_SD2 | B_AC1 | B_DONE;
    localparam logic [23:0] E_RDSTA = B_DATA;
    localparam logic [23:0] E_RDMOV = B_DATA | B_AC2;
    localparam logic [23:0] E_MEMWR = B_SELA | B_MW | B_DONE;
    localparam logic [23:0] E_JNO   = B_PCSRC | B_DONE;
    localparam logic [23:0] E_JYES  = B_PCSRC | B_DONE | B_PCEN;
`ifdef CPU_COND_BRANCH_EN
    localparam logic [23:0] E_JCOND = E_JYES;
`else
    localparam logic [23:0] E_JCOND = E_JNO;
`endif

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // Let inputs settle, check the current cycle, then advance one clock
    task automatic cyc(input string tag, input logic [23:0] exp);
        #1;
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    // Present an opcode during FETCH1, then scramble the live bus afterwards
    task automatic fetch(input string tag, input logic [2:0] op, input logic sub);
        opcode = op;
        subOp  = sub;
        cyc(tag, E_F1);
        opcode = ~op;
        subOp  = ~sub;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; opcode = 3'b000; subOp = 1'b0; zFlag = 1'b0; cFlag = 1'b0;
        @(posedge clk); #1;
        cyc("rst_a", 24'h0);
        cyc("rst_b", 24'h0);
        rst = 1'b0;

        fetch("lda_f1", 3'b000, 1'b0);
        cyc("lda_f2", E_F2);
        cyc("lda_memrd", E_MEMRD);
        cyc("lda_wbw", E_WBW);

        fetch("add_f1", 3'b010, 1'b0);
        cyc("add_f2", E_F2);
        cyc("add_memrd", E_MEMRD);
        cyc("add_alu", E_ADD);
        cyc("add_wbr", E_WBR);

        fetch("and_f1", 3'b011, 1'b0);
        cyc("and_f2", E_F2);
        cyc("and_memrd", E_MEMRD);
        cyc("and_alu", E_AND);
        cyc("and_wbr", E_WBR);

        fetch("sta_f1", 3'b001, 1'b0);
        cyc("sta_f2", E_F2);
        cyc("sta_rdac", E_RDSTA);
        cyc("sta_memwr", E_MEMWR);

        fetch("mov_f1", 3'b111, 1'b0);
        cyc("mov_rdac", E_RDMOV);
        cyc("mov_wbd", E_WBD);

        fetch("jmp_f1", 3'b100, 1'b0);
        cyc("jmp_f2", E_F2);
        cyc("jmp_jump", E_JYES);

        zFlag = 1'b1; cFlag = 1'b0;
        fetch("bz1_f1", 3'b101, 1'b0);
        cyc("bz1_f2", E_F2);
        cyc("bz1_jump", E_JCOND);

        zFlag = 1'b0; cFlag = 1'b1;
        fetch("bz0_f1", 3'b101, 1'b0);
        cyc("bz0_f2", E_F2);
        cyc("bz0_jump", E_JNO);

        fetch("bc1_f1", 3'b110, 1'b0);
        cyc("bc1_f2", E_F2);
        cyc("bc1_jump", E_JCOND);

        zFlag = 1'b1; cFlag = 1'b0;
        fetch("bc0_f1", 3'b110, 1'b0);
        cyc("bc0_f2", E_F2);
        cyc("bc0_jump", E_JNO);

        // Reset asserted while an ADD sits in its ALU cycle
        fetch("radd_f1", 3'b010, 1'b0);
        cyc("radd_f2", E_F2);
        cyc("radd_memrd", E_MEMRD);
        rst = 1'b1;
        cyc("radd_rst", 24'h0);
        rst = 1'b0;
        fetch("radd_refetch", 3'b000, 1'b0);
        cyc("radd_lda_f2", E_F2);
        cyc("radd_lda_memrd", E_MEMRD);
        cyc("radd_lda_wbw", E_WBW);

        fetch("hlt_f1", 3'b111, 1'b1);
        for (int i = 0; i < 20; i++) cyc($sformatf("hlt_%0d", i), B_HALT);
        rst = 1'b1;
        cyc("hlt_rst", 24'h0);
        rst = 1'b0;
        fetch("hlt_after_f1", 3'b100, 1'b0);
        cyc("hlt_after_f2", E_F2);
        cyc("hlt_after_jump", E_JYES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
